// File: rtl/tl_a_d_arbiter_pkg.sv
// Shared TileLink-UH constants and helpers for the A/D-channel arbiter.
package tl_arb_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] GET              = 3'd4;
  localparam logic [2:0] ACCESS_ACK       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam int unsigned BEAT_W = 16;

  // Puts larger than one bus word span several A beats; everything else is one beat.
  function automatic logic [BEAT_W-1:0] beats_from_size(input logic [2:0] opcode,
                                                        input logic [3:0] size,
                                                        input int unsigned lg_bus);
    logic is_put;
    is_put = (opcode == PUT_FULL_DATA) || (opcode == PUT_PARTIAL_DATA);
    if (is_put && (32'(size) > lg_bus))
      beats_from_size = BEAT_W'(1) << (32'(size) - lg_bus);
    else
      beats_from_size = BEAT_W'(1);
  endfunction

endpackage

// File: rtl/tl_a_d_arbiter_if.sv
// TileLink-UH A+D link; LANES>1 gives a flattened multi-requester bundle with broadcast D fields.
interface tl_a_d_arbiter_if #(
  parameter int unsigned LANES     = 1,
  parameter int unsigned SRC_W     = 2,
  parameter int unsigned BUS_SIZE  = 8,
  parameter int unsigned ADR_WIDTH = 32
);
  logic [LANES-1:0]            a_valid;
  logic [LANES-1:0]            a_ready;
  logic [3*LANES-1:0]          a_opcode;
  logic [3*LANES-1:0]          a_param;
  logic [4*LANES-1:0]          a_size;
  logic [SRC_W*LANES-1:0]      a_source;
  logic [ADR_WIDTH*LANES-1:0]  a_address;
  logic [BUS_SIZE*LANES-1:0]   a_mask;
  logic [8*BUS_SIZE*LANES-1:0] a_data;

  logic [LANES-1:0]            d_valid;
  logic [LANES-1:0]            d_ready;
  logic [2:0]                  d_opcode;
  logic [1:0]                  d_param;
  logic [3:0]                  d_size;
  logic [1:0]                  d_sink;
  logic                        d_denied;
  logic [8*BUS_SIZE-1:0]       d_data;
  logic                        d_corrupt;
  logic [SRC_W-1:0]            d_source;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_sink, d_denied, d_data, d_corrupt, d_source,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_sink, d_denied, d_data, d_corrupt, d_source,
    input  d_ready
  );
endinterface

// File: rtl/tl_a_d_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after rr_ptr, or the locked index when lock is set.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       lock,
  input  logic [$clog2(NUM_REQ)-1:0] lock_idx,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_vld
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned j;

  always_comb begin
    grant_idx = lock ? lock_idx : rr_ptr;
    grant_vld = 1'b0;
    j         = 0;
    if (lock) begin
      grant_vld = req[lock_idx];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        j = (32'(rr_ptr) + i) % NUM_REQ;
        if (!grant_vld && req[j]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
    grant = NUM_REQ'(1) << grant_idx;
  end
endmodule

// File: rtl/tl_a_d_arbiter.sv
// Shares one TileLink-UH A/D master port among NUM_REQ requesters; A is round-robin with
// burst lock, D is routed back by the requester index carried in the upper source bits.
module tl_a_d_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SRC_SIZE  = 2,
  parameter int unsigned BUS_SIZE  = 8,
  parameter int unsigned ADR_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  tl_a_d_arbiter_if.slave            up,
  tl_a_d_arbiter_if.master           dn,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       err_unroutable
);
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned LG_BUS = $clog2(BUS_SIZE);
  localparam int unsigned DW     = 8 * BUS_SIZE;

  logic [0:0]         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt, lock_idx, lock_idx_nxt, grant_idx_nxt;
  logic [IDX_W-1:0]   win_idx, ptr_after, d_idx;
  logic               locked, locked_nxt, win_vld, fire, d_routable, err_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_cnt_nxt, beats;
  logic [NUM_REQ-1:0] win_oh, d_oh;
  logic [31:0]        sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (up.a_valid),
    .rr_ptr    (rr_ptr),
    .lock      (locked || (state == BURST)),
    .lock_idx  (lock_idx),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .grant_vld (win_vld)
  );

  // A path: zero-latency mux of the granted requester
  assign sel          = 32'(win_idx);
  assign dn.a_valid   = win_vld && !reset;
  assign dn.a_opcode  = up.a_opcode[3*sel +: 3];
  assign dn.a_param   = up.a_param[3*sel +: 3];
  assign dn.a_size    = up.a_size[4*sel +: 4];
  assign dn.a_source  = {win_idx, up.a_source[SRC_SIZE*sel +: SRC_SIZE]};
  assign dn.a_address = up.a_address[ADR_WIDTH*sel +: ADR_WIDTH];
  assign dn.a_mask    = up.a_mask[BUS_SIZE*sel +: BUS_SIZE];
  assign dn.a_data    = up.a_data[DW*sel +: DW];
  assign up.a_ready   = (reset || !win_vld) ? '0 : (win_oh & {NUM_REQ{dn.a_ready}});

  assign fire      = dn.a_valid && dn.a_ready;
  assign beats     = beats_from_size(dn.a_opcode, dn.a_size, LG_BUS);
  assign ptr_after = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);

  // D path: index in the top source bits selects the requester; out-of-range beats are sunk
  assign d_idx        = dn.d_source[IDX_W+SRC_SIZE-1:SRC_SIZE];
  assign d_routable   = 32'(d_idx) < NUM_REQ;
  assign d_oh         = NUM_REQ'(1) << d_idx;
  assign up.d_valid   = (d_routable && dn.d_valid) ? d_oh : '0;
  assign dn.d_ready   = d_routable ? |(up.d_ready & d_oh) : 1'b1;
  assign up.d_opcode  = dn.d_opcode;
  assign up.d_param   = dn.d_param;
  assign up.d_size    = dn.d_size;
  assign up.d_sink    = dn.d_sink;
  assign up.d_denied  = dn.d_denied;
  assign up.d_data    = dn.d_data;
  assign up.d_corrupt = dn.d_corrupt;
  assign up.d_source  = dn.d_source[SRC_SIZE-1:0];

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    beat_cnt_nxt  = beat_cnt;
    locked_nxt    = locked;
    lock_idx_nxt  = lock_idx;
    grant_idx_nxt = dn.a_valid ? win_idx : grant_idx;
    err_nxt       = dn.d_valid && !d_routable;
    case (state)
      IDLE: begin
        if (fire) begin
          locked_nxt   = 1'b0;
          lock_idx_nxt = win_idx;
          if (beats > BEAT_W'(1)) begin
            state_nxt    = BURST;
            beat_cnt_nxt = beats - BEAT_W'(1);
          end else begin
            rr_ptr_nxt = ptr_after;
          end
        end else if (dn.a_valid) begin
          // stalled beat must keep its grant until it fires
          locked_nxt   = 1'b1;
          lock_idx_nxt = win_idx;
        end
      end
      BURST: begin
        if (fire) begin
          beat_cnt_nxt = beat_cnt - BEAT_W'(1);
          if (beat_cnt == BEAT_W'(1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_after;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      beat_cnt       <= '0;
      locked         <= 1'b0;
      lock_idx       <= '0;
      grant_idx      <= '0;
      err_unroutable <= 1'b0;
    end else begin
      state          <= state_nxt;
      rr_ptr         <= rr_ptr_nxt;
      beat_cnt       <= beat_cnt_nxt;
      locked         <= locked_nxt;
      lock_idx       <= lock_idx_nxt;
      grant_idx      <= grant_idx_nxt;
      err_unroutable <= err_nxt;
    end
  end
endmodule

// File: tb/tb_tl_a_d_arbiter.sv
// Scoreboard bench for tl_a_d_arbiter: A beats and routed D beats are checked against queued expectations.
module tb_tl_a_d_arbiter;
  import tl_arb_pkg::*;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int BS = 8;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int DW = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tl_a_d_arbiter_if #(.LANES(N), .SRC_W(SW),    .BUS_SIZE(BS), .ADR_WIDTH(AW)) up ();
  tl_a_d_arbiter_if #(.LANES(1), .SRC_W(IW+SW), .BUS_SIZE(BS), .ADR_WIDTH(AW)) dn ();
  tl_a_d_arbiter_if #(.LANES(3), .SRC_W(SW),    .BUS_SIZE(BS), .ADR_WIDTH(AW)) up3 ();
  tl_a_d_arbiter_if #(.LANES(1), .SRC_W(IW+SW), .BUS_SIZE(BS), .ADR_WIDTH(AW)) dn3 ();

  logic [IW-1:0] grant_idx, grant_idx3;
  logic          err_unroutable, err_unroutable3;

  tl_a_d_arbiter #(.NUM_REQ(N), .SRC_SIZE(SW), .BUS_SIZE(BS), .ADR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .up(up), .dn(dn),
    .grant_idx(grant_idx), .err_unroutable(err_unroutable)
  );

  tl_a_d_arbiter #(.NUM_REQ(3), .SRC_SIZE(SW), .BUS_SIZE(BS), .ADR_WIDTH(AW)) dut3 (
    .clock(clock), .reset(reset), .up(up3), .dn(dn3),
    .grant_idx(grant_idx3), .err_unroutable(err_unroutable3)
  );

  typedef struct packed {
    logic [2:0] op; logic [3:0] size; logic [SW-1:0] src; logic [AW-1:0] addr; logic [DW-1:0] data;
  } beat_t;
  typedef struct packed { logic [IW+SW-1:0] src; logic [AW-1:0] addr; logic [DW-1:0] data; } aexp_t;
  typedef struct packed { logic [IW-1:0] idx; logic [SW-1:0] src; logic [DW-1:0] data; } dexp_t;

  beat_t  req_q[N][$];
  aexp_t  a_exp[$];
  dexp_t  d_exp[$];
  int     n_vec = 0, n_err = 0;
  int     cyc = 0, n_fire = 0, first_fire = 0, last_fire = 0;
  logic [N-1:0] hs_neg = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #3;
    end
  endtask

  task automatic put_req(input int r, input logic [2:0] op, input logic [3:0] size,
                         input logic [SW-1:0] src, input logic [AW-1:0] addr, input int nbeats);
    beat_t t;
    aexp_t e;
    for (int b = 0; b < nbeats; b++) begin
      t.op = op; t.size = size; t.src = src; t.addr = addr; t.data = {addr, 32'(b)};
      req_q[r].push_back(t);
      e.src = {IW'(r), src}; e.addr = addr; e.data = t.data;
      a_exp.push_back(e);
    end
  endtask

  function automatic bit any_req();
    bit p = 1'b0;
    for (int r = 0; r < N; r++) if (req_q[r].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int max_cyc, input string tag);
    int c = 0;
    while ((a_exp.size() > 0 || any_req()) && c < max_cyc) begin
      tick(1);
      c++;
    end
    check({tag, "_drain"}, 64'(a_exp.size()), 64'(0));
  endtask

  // requester models: hold each beat until its handshake, then present the next one
  always @(posedge clock) begin
    logic [N-1:0] hs;
    hs = hs_neg;
    #1;
    for (int r = 0; r < N; r++) begin
      if (hs[r] && req_q[r].size() > 0) void'(req_q[r].pop_front());
      if (req_q[r].size() > 0) begin
        up.a_valid[r]              = 1'b1;
        up.a_opcode[3*r +: 3]      = req_q[r][0].op;
        up.a_param[3*r +: 3]       = 3'd0;
        up.a_size[4*r +: 4]        = req_q[r][0].size;
        up.a_source[SW*r +: SW]    = req_q[r][0].src;
        up.a_address[AW*r +: AW]   = req_q[r][0].addr;
        up.a_mask[BS*r +: BS]      = '1;
        up.a_data[DW*r +: DW]      = req_q[r][0].data;
      end else begin
        up.a_valid[r] = 1'b0;
      end
    end
  end

  // output monitor, sampled mid-cycle
  always @(negedge clock) begin
    aexp_t ae;
    dexp_t de;
    cyc++;
    hs_neg = up.a_valid & up.a_ready;
    if (dn.a_valid && dn.a_ready) begin
      n_fire++;
      last_fire = cyc;
      if (n_fire == 1) first_fire = cyc;
      check("a_pending", 64'(a_exp.size() > 0), 64'(1));
      if (a_exp.size() > 0) begin
        ae = a_exp.pop_front();
        check("a_source", 64'(dn.a_source), 64'(ae.src));
        check("a_address", 64'(dn.a_address), 64'(ae.addr));
        check("a_data", dn.a_data, ae.data);
        check("a_ready_oh", 64'(up.a_ready), 64'(1) << ae.src[IW+SW-1:SW]);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (up.d_valid[k] && up.d_ready[k]) begin
        check("d_pending", 64'(d_exp.size() > 0), 64'(1));
        if (d_exp.size() > 0) begin
          de = d_exp.pop_front();
          check("d_route", 64'(k), 64'(de.idx));
          check("d_source", 64'(up.d_source), 64'(de.src));
          check("d_data", up.d_data, de.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    dexp_t de;
    int    b, t;
    up.d_ready = '1;
    dn.a_ready = 1'b0;
    dn.d_valid = 1'b0; dn.d_opcode = '0; dn.d_param = '0; dn.d_size = '0; dn.d_sink = '0;
    dn.d_denied = 1'b0; dn.d_data = '0; dn.d_corrupt = 1'b0; dn.d_source = '0;
    up3.a_valid = '0; up3.a_opcode = '0; up3.a_param = '0; up3.a_size = '0; up3.a_source = '0;
    up3.a_address = '0; up3.a_mask = '0; up3.a_data = '0; up3.d_ready = '0;
    dn3.a_ready = 1'b0;
    dn3.d_valid = 1'b0; dn3.d_opcode = '0; dn3.d_param = '0; dn3.d_size = '0; dn3.d_sink = '0;
    dn3.d_denied = 1'b0; dn3.d_data = '0; dn3.d_corrupt = 1'b0; dn3.d_source = '0;

    reset = 1'b1;
    tick(2);
    check("rst_grant_idx", 64'(grant_idx), 64'(0));
    check("rst_err", 64'(err_unroutable), 64'(0));
    check("rst_dn_a_valid", 64'(dn.a_valid), 64'(0));
    reset = 1'b0;

    // all four Gets at once -> 0,1,2,3 on consecutive cycles
    dn.a_ready = 1'b1;
    n_fire = 0;
    for (int r = 0; r < N; r++) put_req(r, GET, 4'd3, SW'(r + 1), 32'h1000 + 32'(r) * 32'h10, 1);
    drain(20, "s1");
    check("s1_span", 64'(last_fire - first_fire), 64'(3));
    check("s1_grant_idx", 64'(grant_idx), 64'(3));

    // move pointer to 1, then 8-beat Put from req1 with req0/req2 pending
    put_req(0, GET, 4'd3, 2'd1, 32'h2000, 1);
    drain(10, "s2a");
    n_fire = 0;
    put_req(1, PUT_FULL_DATA, 4'd6, 2'd2, 32'h3000, 8);
    put_req(2, GET, 4'd3, 2'd3, 32'h3100, 1);
    put_req(0, GET, 4'd3, 2'd0, 32'h3200, 1);
    drain(40, "s2");
    check("s2_span", 64'(last_fire - first_fire), 64'(9));

    // backpressure: req0 stalled, req3 arrives, payload must hold
    dn.a_ready = 1'b0;
    put_req(0, GET, 4'd3, 2'd1, 32'h4000, 1);
    tick(1);
    put_req(3, GET, 4'd3, 2'd2, 32'h4300, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("s3_hold_valid", 64'(dn.a_valid), 64'(1));
      check("s3_hold_addr", 64'(dn.a_address), 64'(32'h4000));
      check("s3_hold_src", 64'(dn.a_source), 64'(4'b0001));
    end
    dn.a_ready = 1'b1;
    drain(10, "s3");

    // 4-beat AccessAckData to requester 2 with toggling ready
    for (int k = 0; k < 4; k++) begin
      de.idx = 2'd2; de.src = 2'b01; de.data = 64'hD000 + 64'(k);
      d_exp.push_back(de);
    end
    dn.d_valid = 1'b1; dn.d_opcode = ACCESS_ACK_DATA; dn.d_size = 4'd5; dn.d_source = 4'b1001;
    b = 0; t = 0;
    while (b < 4 && t < 20) begin
      dn.d_data  = 64'hD000 + 64'(b);
      up.d_ready = 4'b1011 | ((t % 2 == 1) ? 4'b0100 : 4'b0000);
      #1;
      check("s4_d_valid_oh", 64'(up.d_valid), 64'(4'b0100));
      check("s4_d_src", 64'(up.d_source), 64'(2'b01));
      check("s4_d_ready", 64'(dn.d_ready), 64'(t % 2));
      @(posedge clock);
      #3;
      if (t % 2 == 1) b++;
      t++;
    end
    dn.d_valid = 1'b0;
    up.d_ready = '1;
    check("s4_d_done", 64'(d_exp.size()), 64'(0));

    // NUM_REQ=3: index 3 is dropped with an error pulse, index 2 routes normally
    dn3.d_valid = 1'b1; dn3.d_source = 4'b1100; up3.d_ready = 3'b000;
    #1;
    check("s5_drop_ready", 64'(dn3.d_ready), 64'(1));
    check("s5_drop_valid", 64'(up3.d_valid), 64'(0));
    check("s5_err_pre", 64'(err_unroutable3), 64'(0));
    tick(1);
    dn3.d_source = 4'b1011; up3.d_ready = 3'b100;
    #1;
    check("s5_err_pulse", 64'(err_unroutable3), 64'(1));
    check("s5_route_valid", 64'(up3.d_valid), 64'(3'b100));
    check("s5_route_ready", 64'(dn3.d_ready), 64'(1));
    up3.d_ready = 3'b011;
    #1;
    check("s5_route_bp", 64'(dn3.d_ready), 64'(0));
    tick(1);
    dn3.d_valid = 1'b0;
    check("s5_err_once", 64'(err_unroutable3), 64'(0));

    // reset during an 8-beat Put from req2 (pointer parked at 2 beforehand)
    put_req(1, GET, 4'd3, 2'd1, 32'h5000, 1);
    drain(10, "s6a");
    n_fire = 0;
    put_req(2, PUT_PARTIAL_DATA, 4'd6, 2'd3, 32'h6000, 8);
    t = 0;
    while (n_fire < 3 && t < 20) begin
      tick(1);
      t++;
    end
    check("s6_beats_before_rst", 64'(n_fire), 64'(3));
    reset = 1'b1;
    #1;
    check("s6_rst_dn_valid", 64'(dn.a_valid), 64'(0));
    check("s6_rst_up_ready", 64'(up.a_ready), 64'(0));
    req_q[2].delete();
    a_exp.delete();
    tick(1);
    reset = 1'b0;
    check("s6_rst_grant_idx", 64'(grant_idx), 64'(0));
    put_req(0, GET, 4'd3, 2'd2, 32'h7000, 1);
    put_req(2, GET, 4'd3, 2'd0, 32'h7200, 1);
    drain(10, "s6");
    check("s6_no_err", 64'(err_unroutable), 64'(0));

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
